// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, default transmit FIFO depth and byte type.
package uart_pkg;

    localparam int UART_BYTE_W        = 8;
    localparam int UART_TX_FIFO_DEPTH = 64;

    typedef logic [UART_BYTE_W-1:0] uart_byte_t;

endpackage : uart_pkg

// File: rtl/fifo_mem_2p.sv
// Simple dual-port byte array: synchronous write port, asynchronous read port.
// Maps onto distributed RAM; contents are intentionally not reset.
module fifo_mem_2p
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_TX_FIFO_DEPTH
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [UART_BYTE_W-1:0]   wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [UART_BYTE_W-1:0]   rd_data
);

    uart_byte_t mem [DEPTH];

    // Write port: store one byte per enabled clock edge.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule : fifo_mem_2p

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the uart transmitter. The bus side pushes bytes, the uart
// consumes the head and pops it with tx_complete at the start of the stop bit.
// Optional feature macro: UART_TX_FIFO_WATERMARK_EN enables the registered
// low_water refill indication; without it low_water is tied to 0.
//
// Handshakes: a write is accepted on a clock edge where wr_valid=1, full=0 and
// flush=0; a write while full is dropped and sets the sticky overflow flag.
// The head is offered while tx_valid=1; tx_complete is a single-cycle pulse
// that consumes it, and is ignored while tx_valid=0. tx_data stays stable
// from tx_valid rising until the consuming tx_complete edge.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH     = UART_TX_FIFO_DEPTH,
    parameter int LOW_WATER = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_valid,
    input  logic [UART_BYTE_W-1:0] wr_data,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    input  logic                   flush,
    output logic                   tx_valid,
    output logic [UART_BYTE_W-1:0] tx_data,
    input  logic                   tx_complete,
    output logic                   low_water
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LW_C    = CW'(LOW_WATER);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          empty;
    logic          push;
    logic          pop;

    // Full and empty come from the registered count, so a same-cycle pop never
    // makes room for a write into a full FIFO.
    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_C);
    assign level    = count_q;
    assign tx_valid = !empty;

    assign push = wr_valid && !full && !flush;
    assign pop  = tx_complete && !empty;

    fifo_mem_2p #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clock   (clock),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr),
        .rd_data (tx_data)
    );

    // Pointer, count and overflow update; flush keeps only the possibly in-flight head.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            overflow <= 1'b0;
            if (!empty) begin
                wr_ptr <= rd_ptr + 1'b1;
                if (pop) begin
                    rd_ptr  <= rd_ptr + 1'b1;
                    count_q <= '0;
                end else begin
                    count_q <= CW'(1);
                end
            end
        end else begin
            if (wr_valid && full) begin
                overflow <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef UART_TX_FIFO_WATERMARK_EN
    logic low_water_q;

    // Refill indication, one cycle behind the count it is derived from.
    always_ff @(posedge clock) begin
        if (reset) begin
            low_water_q <= 1'b0;
        end else begin
            low_water_q <= (count_q <= LW_C);
        end
    end

    assign low_water = low_water_q;
`else
    logic unused_low_water_cfg;

    assign unused_low_water_cfg = ^LW_C;
    assign low_water            = 1'b0;
`endif

endmodule : uart_tx_fifo

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a table of short vectors from reset,
// hand-written corner sequences, and a random phase, all checked against a
// queue-based reference model of the stored bytes.
module tb_uart_tx_fifo;

    localparam int DEPTH     = 64;
    localparam int LOW_WATER = 8;

    logic       clock;
    logic       reset;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       full;
    logic [6:0] level;
    logic       overflow;
    logic       flush;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_complete;
    logic       low_water;

    uart_tx_fifo #(
        .DEPTH     (DEPTH),
        .LOW_WATER (LOW_WATER)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .full        (full),
        .level       (level),
        .overflow    (overflow),
        .flush       (flush),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_complete (tx_complete),
        .low_water   (low_water)
    );

    // Clock and reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard state
    logic [7:0] exp_q[$];
    logic       m_ovf;
    logic       m_lw;
    int         pass_cnt;
    int         total_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_outputs();
        int lvl;
        lvl = exp_q.size();
        chk("level", 32'(level), 32'(lvl));
        chk("full", 32'(full), 32'(lvl == DEPTH));
        chk("tx_valid", 32'(tx_valid), 32'(lvl != 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("low_water", 32'(low_water), 32'(m_lw));
        if (lvl != 0) begin
            chk("tx_data", 32'(tx_data), 32'(exp_q[0]));
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        wr_valid    = 1'b0;
        wr_data     = 8'h00;
        tx_complete = 1'b0;
        flush       = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        m_ovf = 1'b0;
        m_lw  = 1'b0;
        check_outputs();
    endtask

    // Driver: one clock cycle of stimulus, model update, then output check.
    task automatic cycle(input logic wr, input logic [7:0] d, input logic pop, input logic fl);
        int   old_level;
        logic was_full;
        wr_valid    = wr;
        wr_data     = d;
        tx_complete = pop;
        flush       = fl;
        old_level   = exp_q.size();
        was_full    = (old_level == DEPTH);
        if (fl) begin
            m_ovf = 1'b0;
            if (old_level != 0) begin
                while (exp_q.size() > 1) void'(exp_q.pop_back());
                if (pop) void'(exp_q.pop_front());
            end
        end else begin
            if (wr && was_full) m_ovf = 1'b1;
            if (pop && old_level != 0) void'(exp_q.pop_front());
            if (wr && !was_full) exp_q.push_back(d);
        end
`ifdef UART_TX_FIFO_WATERMARK_EN
        m_lw = (old_level <= LOW_WATER);
`else
        m_lw = 1'b0;
`endif
        tick();
        wr_valid    = 1'b0;
        tx_complete = 1'b0;
        flush       = 1'b0;
        check_outputs();
    endtask

    task automatic fill(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 8'(base + i), 1'b0, 1'b0);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            guard++;
        end
        chk("drain_empty", 32'(level), 32'd0);
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       pop;
        logic       fl;
        int         e_level;
        logic [7:0] e_data;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[11];

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;

        //           wr    data   pop   flush level data   ovf
        vecs[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1, 8'h41, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0};
        vecs[3]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 1, 8'h5A, 1'b0};
        vecs[4]  = '{1'b1, 8'h5B, 1'b1, 1'b0, 1, 8'h5B, 1'b0};
        vecs[5]  = '{1'b1, 8'h5C, 1'b0, 1'b0, 2, 8'h5B, 1'b0};
        vecs[6]  = '{1'b1, 8'h5D, 1'b0, 1'b1, 1, 8'h5B, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 8'h00, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 8'h00, 1'b0};
        vecs[9]  = '{1'b1, 8'h66, 1'b0, 1'b0, 1, 8'h66, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0};

        do_reset();

        // Table-driven vectors with fixed expectations
        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i].wr, vecs[i].d, vecs[i].pop, vecs[i].fl);
            chk($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].e_level));
            chk($sformatf("vec%0d_valid", i), 32'(tx_valid), 32'(vecs[i].e_level != 0));
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
            if (vecs[i].e_level != 0) begin
                chk($sformatf("vec%0d_data", i), 32'(tx_data), 32'(vecs[i].e_data));
            end
        end

        // Fill to full, write while full, drain in order
        fill(64, 0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_level", 32'(level), 32'd64);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_level", 32'(level), 32'd64);
        for (int i = 0; i < 64; i++) begin
            chk("drain_order", 32'(tx_data), 32'(i));
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drained_valid", 32'(tx_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Write while full with same-cycle pop: byte dropped
        do_reset();
        fill(64, 8'h80);
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        chk("fullpop_level", 32'(level), 32'd63);
        chk("fullpop_ovf", 32'(overflow), 32'd1);
        drain();

        // Push+pop streaming across the write-pointer wrap
        do_reset();
        fill(60, 0);
        drain();
        fill(5, 8'hC0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'(8'hD0 + i), 1'b1, 1'b0);
            chk("stream_level", 32'(level), 32'd5);
        end
        drain();

        // Flush keeps the head and clears overflow; flush beats a full write
        do_reset();
        cycle(1'b1, 8'h10, 1'b0, 1'b0);
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 8'h12, 1'b0, 1'b0);
        fill(61, 8'h20);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("pre_flush_ovf", 32'(overflow), 32'd1);
        cycle(1'b1, 8'hEF, 1'b0, 1'b1);
        chk("flush_level", 32'(level), 32'd1);
        chk("flush_head", 32'(tx_data), 32'h10);
        chk("flush_ovf", 32'(overflow), 32'd0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("flush_pop_level", 32'(level), 32'd0);

`ifdef UART_TX_FIFO_WATERMARK_EN
        // Watermark follows the level one cycle late
        fill(9, 8'h30);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("lw_at9", 32'(low_water), 32'd0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("lw_at8_same", 32'(low_water), 32'd0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("lw_at8_late", 32'(low_water), 32'd1);
        drain();
`endif

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 2));
        end

        // Reset with data queued empties the FIFO
        fill(4, 8'h70);
        do_reset();
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_valid", 32'(tx_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_uart_tx_fifo

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte FIFO between the CPU/peripheral write path and the uart transmitter. It accepts bytes from the bus side and presents the head entry to the uart on tx_valid/tx_data. It pops the head on the uart's tx_complete pulse. It decouples CPU writes from the 2 Mbaud line rate so software can burst up to DEPTH bytes without polling.

Parameters:
DEPTH, 64, number of byte entries; power of two, minimum 2.
LOW_WATER, 8, level at or below which low_water asserts (only with UART_TX_FIFO_WATERMARK_EN).

Ports:
clock  in  1  system clock (100 MHz).
reset  in  1  reset; synchronous, active-high.
wr_valid  in  1  write strobe from the bus side; one byte per cycle when high.
wr_data  in  8  byte to enqueue.
full  out  1  high when level==DEPTH.
level  out  $clog2(DEPTH)+1  number of stored bytes, including the head being transmitted.
overflow  out  1  sticky; set when a write was dropped because the FIFO was full.
flush  in  1  discards queued bytes and clears overflow.
tx_valid  out  1  to uart; high when level!=0.
tx_data  out  8  to uart; the head entry.
tx_complete  in  1  from uart; single-cycle pulse, pops the head.
low_water  out  1  watermark indication (see Optional Feature).

Behaviour:
- Storage: DEPTH x 8 array, wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH. The count register is $clog2(DEPTH)+1 bits; full and empty are derived from the count, not from pointer compare.
- Reset: wr_ptr=rd_ptr=0, level=0, full=0, overflow=0, tx_valid=0, low_water=0. tx_data is don't-care while tx_valid=0. Array contents are not reset.
- Push: wr_valid && !full writes mem[wr_ptr], increments wr_ptr, and increments level at the clock edge.
- Push while full: the byte is dropped, nothing changes, and overflow is set the next cycle. This applies even if tx_complete pops in the same cycle, because full is evaluated on the registered level.
- Pop: tx_complete && level!=0 increments rd_ptr and decrements level. tx_complete while empty is ignored.
- Simultaneous push+pop, not full and not empty: both pointers advance and level is unchanged.
- Simultaneous push+pop when empty: the push proceeds and the pop is ignored, so level becomes 1.
- tx_data: combinational read of mem[rd_ptr], held stable until the pop. The uart reads tx_data throughout the frame. The pop lands at the start of the stop bit, so a head change never corrupts a data bit.
- tx_valid: equals level!=0. Latency from a write into an empty FIFO to tx_valid=1 is 1 cycle.
- Flush:
  - If level!=0, the head is kept because it may be in flight. wr_ptr becomes rd_ptr+1 and level becomes 1.
  - If level==0, nothing changes.
  - overflow is cleared.
  - flush has priority over a same-cycle push, which is dropped without setting overflow.
  - A same-cycle tx_complete still pops the head, giving level=0 and wr_ptr=rd_ptr after the increment.
- Reset mid-frame: the FIFO empties immediately. The uart is reset by the same signal, so the frame is abandoned.
- No state machine beyond the count. All outputs are registered except tx_data, tx_valid and full, which are decoded from registers.

Optional Feature:
UART_TX_FIFO_WATERMARK_EN:
- Defined: low_water is a registered output, high when level<=LOW_WATER (updated the cycle after level changes), and 0 in reset. Used as a refill interrupt.
- Undefined: low_water is tied to 0 and the LOW_WATER parameter is unused.

Decomposition:
- Package uart_pkg holds UART_BYTE_W=8, the default UART_TX_FIFO_DEPTH=64, and a typedef for the byte.
- One sub-module is natural: fifo_mem_2p, a DEPTH x 8 simple dual-port array with a synchronous write and an asynchronous read, suitable for distributed RAM.
- Pointer and count logic stay in uart_tx_fifo.

Test Plan:
- Reset, then write 0x41 in one cycle -> next cycle tx_valid=1, tx_data=0x41, level=1. Pulse tx_complete -> tx_valid=0, level=0.
- Write 64 bytes 0x00..0x3F back-to-back -> full=1, level=64. Write 0xAA -> overflow=1, level=64. Pop all 64 -> bytes come out 0x00..0x3F in order, 0xAA never appears.
- Fill to 64, then in one cycle assert wr_valid (0x55) and tx_complete -> level=63, byte dropped, overflow=1.
- Level=5, hold wr_valid and tx_complete high together for 10 cycles -> level stays 5 and ordering is preserved across the wrap of wr_ptr past 63.
- Queue 0x10,0x11,0x12, overflow set, then pulse flush -> level=1, tx_data=0x10, overflow=0. Pop -> level=0.
- With UART_TX_FIFO_WATERMARK_EN: level 9 -> low_water=0. Pop to 8 -> low_water=1 one cycle later. Without the macro, low_water stays 0 throughout.
